// File: rtl/alu_seq_pkg.sv
// Types for the multi-cycle ALU sequencer.
// Provides the request op encoding, the FSM state enum and the multiply
// iteration bound. No ports; imported with alu_seq_pkg::*.
package alu_seq_pkg;

  typedef enum logic [1:0] {
    SEQ_ADD16 = 2'b00,
    SEQ_SUB16 = 2'b01,
    SEQ_MUL8  = 2'b10,
    SEQ_RSVD  = 2'b11
  } seq_op_e;

  typedef enum logic [3:0] {
    IDLE,
    LO_ISS,
    LO_SMP,
    HI_ISS,
    HI_SMP,
    FX_ISS,
    FX_SMP,
    MBIT,
    M_ISS,
    M_SMP,
    RESP
  } state_e;

  // Value of the 3-bit iteration counter during the eighth multiply step.
  localparam logic [2:0] MUL_LAST = 3'd7;

endpackage

// File: rtl/global_defines.sv
// Shared execute-stage definitions.
// Holds the 8-bit ALU mode encodings used by every block that drives the ALU.
// No ports; imported with global_defines::*.
package global_defines;

  // ALU mode codes. ALU_NON leaves the ALU's latched mode untouched.
  localparam logic [7:0] ALU_NON = 8'h00;
  localparam logic [7:0] ALU_ADD = 8'h01;
  localparam logic [7:0] ALU_SUB = 8'h02;

endpackage

// File: rtl/alu_seq_if.sv
// Request/response handshake bundle between the execute stage and the
// ALU sequencer.
//   req_valid/req_ready : request handshake, req_op/req_a/req_b its payload
//   rsp_valid/rsp_ready : response handshake, rsp_result/rsp_carry/rsp_zero
// Modports: master = execute stage (issues requests, consumes results),
//           slave  = sequencer.
interface alu_seq_if;
  import alu_seq_pkg::*;

  logic        req_valid;
  logic        req_ready;
  seq_op_e     req_op;
  logic [15:0] req_a;
  logic [15:0] req_b;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_result;
  logic        rsp_carry;
  logic        rsp_zero;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_carry, rsp_zero
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_carry, rsp_zero
  );

endinterface

// File: rtl/alu_seq.sv
// Multi-cycle sequencer driving the shared 8-bit ALU to perform 16-bit
// ADD/SUB and 8x8 unsigned multiply.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   bus (slave)         : request/response handshakes
//   busy                : an operation is in flight
//   alu_a/alu_b/alu_mode: ALU operand and mode drive
//   alu_out/alu_carry   : ALU result and carry/borrow read back
// Every ALU pass is an ISS cycle (mode + operands driven) followed by an SMP
// cycle (mode back to ALU_NON, operands held, result captured).
module alu_seq
  import global_defines::*;
  import alu_seq_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  alu_seq_if.slave    bus,
  output logic        busy,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [7:0]  alu_mode,
  input  logic [7:0]  alu_out,
  input  logic        alu_carry
);

  state_e      state;
  seq_op_e     op_q;
  logic [15:0] a_q;
  logic [7:0]  b_hi;
  logic [7:0]  rl;       // low result byte
  logic        c0;       // carry/borrow out of the low pass
  logic        c1;       // carry/borrow out of the high pass
  logic [7:0]  p_hi;     // upper partial product
  logic [7:0]  mlo;      // multiplier bits, refilled with product bits
  logic [2:0]  cnt;      // completed multiply iterations

  logic [15:0] mul_shift;
  logic [15:0] mul_add;

  // {P_hi, mlo} shifted right one place, without and with the ALU sum.
  assign mul_shift = {1'b0, p_hi, mlo[7:1]};
  assign mul_add   = {alu_carry, alu_out, mlo[7:1]};

  assign busy           = (state != IDLE);
  assign bus.req_ready  = (state == IDLE);
  assign bus.rsp_valid  = (state == RESP);

  // NOTE: every output of an always_comb gets a default first so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    alu_mode = ALU_NON;
    case (state)
      LO_ISS, HI_ISS, FX_ISS: alu_mode = (op_q == SEQ_SUB16) ? ALU_SUB : ALU_ADD;
      M_ISS:                  alu_mode = ALU_ADD;
      default:                alu_mode = ALU_NON;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from the values present before the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      op_q       <= SEQ_ADD16;
      a_q        <= '0;
      b_hi       <= '0;
      rl         <= '0;
      c0         <= 1'b0;
      c1         <= 1'b0;
      p_hi       <= '0;
      mlo        <= '0;
      cnt        <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      bus.rsp_result <= '0;
      bus.rsp_carry  <= 1'b0;
      bus.rsp_zero   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            op_q <= bus.req_op;
            a_q  <= bus.req_a;
            b_hi <= bus.req_b[15:8];
            case (bus.req_op)
              SEQ_ADD16, SEQ_SUB16: begin
                alu_a <= bus.req_a[7:0];
                alu_b <= bus.req_b[7:0];
                state <= LO_ISS;
              end
              SEQ_MUL8: begin
                p_hi  <= '0;
                mlo   <= bus.req_b[7:0];
                cnt   <= '0;
                state <= MBIT;
              end
              default: begin
                bus.rsp_result <= '0;
                bus.rsp_carry  <= 1'b0;
                bus.rsp_zero   <= 1'b1;
                state          <= RESP;
              end
            endcase
          end
        end

        LO_ISS: state <= LO_SMP;

        LO_SMP: begin
          rl    <= alu_out;
          c0    <= alu_carry;
          alu_a <= a_q[15:8];
          alu_b <= b_hi;
          state <= HI_ISS;
        end

        HI_ISS: state <= HI_SMP;

        HI_SMP: begin
          if (c0) begin
            // Propagate the low-byte carry/borrow into the high byte.
            c1    <= alu_carry;
            alu_a <= alu_out;
            alu_b <= 8'd1;
            state <= FX_ISS;
          end else begin
            bus.rsp_result <= {alu_out, rl};
            bus.rsp_carry  <= alu_carry;
            bus.rsp_zero   <= ({alu_out, rl} == 16'd0);
            state          <= RESP;
          end
        end

        FX_ISS: state <= FX_SMP;

        FX_SMP: begin
          bus.rsp_result <= {alu_out, rl};
          bus.rsp_carry  <= c1 | alu_carry;
          bus.rsp_zero   <= ({alu_out, rl} == 16'd0);
          state          <= RESP;
        end

        MBIT: begin
          if (mlo[0]) begin
            alu_a <= p_hi;
            alu_b <= a_q[7:0];
            state <= M_ISS;
          end else begin
            {p_hi, mlo} <= mul_shift;
            cnt         <= cnt + 3'd1;
            if (cnt == MUL_LAST) begin
              bus.rsp_result <= mul_shift;
              bus.rsp_carry  <= 1'b0;
              bus.rsp_zero   <= (mul_shift == 16'd0);
              state          <= RESP;
            end
          end
        end

        M_ISS: state <= M_SMP;

        M_SMP: begin
          {p_hi, mlo} <= mul_add;
          cnt         <= cnt + 3'd1;
          if (cnt == MUL_LAST) begin
            bus.rsp_result <= mul_add;
            bus.rsp_carry  <= 1'b0;
            bus.rsp_zero   <= (mul_add == 16'd0);
            state          <= RESP;
          end else begin
            state <= MBIT;
          end
        end

        RESP: if (bus.rsp_ready) state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

endmodule
